lm_write_sequencer: RTL

Write-side sequencer for the 8-entry, 16-bit register bank. It executes Load-Multiple (LM) in the memory/write-back stage. From an 8-bit register mask and a base address it issues one data-memory read per selected register and drives the bank's write port (`write`/`writeAdd`/`in`) one register per cycle, lowest index first. While it runs it holds the pipeline with `busy`.

---
 rtl/lm_write_sequencer_pkg.sv | 18 +
 rtl/lowest_set_bit8.sv | 23 ++
 rtl/lm_write_sequencer.sv | 118 +++++++++++
 3 files changed

// File: rtl/lm_write_sequencer_pkg.sv
// Shared definitions for the Load-Multiple write sequencer.
package lm_write_sequencer_pkg;

  // Register bank geometry
  localparam int NREGS  = 8;
  localparam int RIDX_W = 3;

  // Index of the program counter inside the register bank
  localparam logic [RIDX_W-1:0] REG_PC = 3'd7;

  // Sequencer states: waiting, issuing reads, draining the final write
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    LAST = 2'd2
  } lm_state_t;

endpackage

// File: rtl/lowest_set_bit8.sv
// Combinational priority encoder: index of the lowest set bit of an 8-bit mask.
module lowest_set_bit8
  import lm_write_sequencer_pkg::*;
(
  input  logic [NREGS-1:0]  vec,
  output logic [RIDX_W-1:0] idx,
  output logic              none
);

  // Scan from the top down so the lowest set bit is the one left standing
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    idx  = '0;
    none = 1'b1;
    for (int i = NREGS - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx  = RIDX_W'(i);
        none = 1'b0;
      end
    end
  end

endmodule

// File: rtl/lm_write_sequencer.sv
// Load-Multiple write sequencer: one memory read per selected register,
// then one register-bank write per cycle, lowest register index first.
module lm_write_sequencer
  import lm_write_sequencer_pkg::*;
#(
  parameter int DW = 16,
  parameter int AW = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [NREGS-1:0]  mask,
  input  logic [AW-1:0]     base,
  output logic              mem_rd,
  output logic [AW-1:0]     mem_addr,
  input  logic [DW-1:0]     mem_data,
  output logic              rf_write,
  output logic [RIDX_W-1:0] rf_write_add,
  output logic [DW-1:0]     rf_in,
  output logic              busy,
  output logic              done,
  output logic              r7_loaded
);

  lm_state_t         state, stateNext;
  logic [NREGS-1:0]  pend, pendNext, srcVec;
  logic [AW-1:0]     addr, addrNext, addrSrc, memAddrNext;
  logic [RIDX_W-1:0] issIdx, issIdxNext, lsbIdx;
  logic              lsbNone, memRdNext, doneNext, issue;

  // The first issue comes straight from the request; later ones from the pending mask
  assign srcVec  = (state == IDLE) ? mask : pend;
  assign addrSrc = (state == IDLE) ? base : addr;

  lowest_set_bit8 uLsb (
    .vec  (srcVec),
    .idx  (lsbIdx),
    .none (lsbNone)
  );

  // Memory is registered, so read data lines up with the write issued the cycle after the read
  assign rf_in = mem_data;

  // Next-state and next-issue decision
  always_comb begin
    stateNext   = state;
    pendNext    = pend;
    addrNext    = addr;
    memRdNext   = 1'b0;
    memAddrNext = mem_addr;
    issIdxNext  = issIdx;
    doneNext    = 1'b0;
    issue       = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          pendNext = mask;
          addrNext = base;
          if (lsbNone) doneNext = 1'b1;
          else         issue    = 1'b1;
        end
      end
      RUN: begin
        // No register left to read: the outstanding read turns into the final write
        if (lsbNone) begin
          stateNext = LAST;
          doneNext  = 1'b1;
        end else begin
          issue = 1'b1;
        end
      end
      LAST:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase

    if (issue) begin
      stateNext   = RUN;
      memRdNext   = 1'b1;
      memAddrNext = addrSrc;
      issIdxNext  = lsbIdx;
      pendNext    = srcVec & ~(NREGS'(1) << lsbIdx);
      addrNext    = addrSrc + AW'(1);
    end
  end

  // State, datapath and registered outputs; the write stage trails the read stage by one cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: reset clears every register here, including the write pipe, so an in-flight read never lands.
      state        <= IDLE;
      pend         <= '0;
      addr         <= '0;
      issIdx       <= '0;
      mem_rd       <= 1'b0;
      mem_addr     <= '0;
      rf_write     <= 1'b0;
      rf_write_add <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      r7_loaded    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state        <= stateNext;
      pend         <= pendNext;
      addr         <= addrNext;
      issIdx       <= issIdxNext;
      mem_rd       <= memRdNext;
      mem_addr     <= memAddrNext;
      rf_write     <= mem_rd;
      rf_write_add <= issIdx;
      busy         <= memRdNext | mem_rd;
      done         <= doneNext;
      r7_loaded    <= mem_rd && (issIdx == REG_PC);
    end
  end

endmodule
